// File: rtl/base_address_wr_if.sv
// Entry stream and native BRAM port of the CWBP mapping-table writer.
// The writer sits on the slave side of the entry stream and drives the BRAM port.
interface base_address_wr_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_way;
  logic [31:0] in_row;
  logic        in_last;

  logic        ram_clk;
  logic        ram_rst;
  logic [31:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wd_data;
  logic [31:0] ram_rd_data;

  modport master (
    output in_valid, in_way, in_row, in_last, ram_rd_data,
    input  in_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data
  );

  modport slave (
    input  in_valid, in_way, in_row, in_last, ram_rd_data,
    output in_ready, ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data
  );
endinterface

// File: rtl/base_address_wr.sv
// Encodes (way, row) entries into CWBP mapping pointers, writes them sequentially
// into the mapping-table BRAM, appends an entry-count word and pulses Transfer_Done.
module base_address_wr #(
  parameter logic [31:0] START_ADDR   = 32'h4580_0000,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  base_address_wr_if.slave  bus,
  output logic              busy,
  output logic              range_err,
  output logic              Transfer_Done
);

  localparam int unsigned IDX_W      = $clog2(DEPTH) + 1;
  localparam logic [31:0] COUNT_ADDR = START_ADDR + 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    in_ready_q;
  logic                    ram_en_q;
  logic [3:0]              ram_we_q;
  logic [31:0]             ram_addr_q;
  logic [C_DATA_WIDTH-1:0] ram_wd_data_q;
  logic                    busy_q;
  logic                    range_err_q;
  logic                    done_q;

  logic                    hs_s;
  logic                    last_s;
  logic [C_DATA_WIDTH-1:0] ptr_s;
  logic [31:0]             entry_addr_s;

  // Pointer field layout is the exact inverse of the CWBP decoder split.
  assign ptr_s        = {bus.in_way, bus.in_row[27:0]};
  assign entry_addr_s = START_ADDR + {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
  assign hs_s         = bus.in_valid & in_ready_q & (state_q == ACCEPT);
  // A full table closes exactly as if the entry had carried in_last.
  assign last_s       = bus.in_last | (idx_q == IDX_W'(DEPTH - 1));

  // Table-write sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      in_ready_q    <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 4'h0;
      ram_addr_q    <= 32'h0000_0000;
      ram_wd_data_q <= '0;
      busy_q        <= 1'b0;
      range_err_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 4'h0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q       <= '0;
            range_err_q <= 1'b0;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (hs_s) begin
            ram_en_q      <= 1'b1;
            ram_we_q      <= 4'hF;
            ram_addr_q    <= entry_addr_s;
            ram_wd_data_q <= ptr_s;
            idx_q         <= idx_q + IDX_W'(1);
            if (bus.in_row[31:28] != 4'h0) begin
              range_err_q <= 1'b1;
            end
            if (last_s) begin
              in_ready_q <= 1'b0;
              state_q    <= COUNT;
            end
          end
        end
        COUNT: begin
          ram_en_q      <= 1'b1;
          ram_we_q      <= 4'hF;
          ram_addr_q    <= COUNT_ADDR;
          ram_wd_data_q <= C_DATA_WIDTH'(idx_q);
          state_q       <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_clk     = clk;
  assign bus.ram_rst     = ~rst_n;
  assign bus.in_ready    = in_ready_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wd_data = ram_wd_data_q;
  assign busy            = busy_q;
  assign range_err       = range_err_q;
  assign Transfer_Done   = done_q;

endmodule

// File: tb/tb_base_address_wr.sv
// Directed and randomized bench for base_address_wr, checked against a
// write-list model built from table position arithmetic.
module tb_base_address_wr;
  localparam logic [31:0] START = 32'h4580_0000;
  localparam int          DEPTH = 32;
  localparam logic [31:0] CADDR = START + 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic range_err;
  logic done;

  int checks   = 0;
  int failures = 0;

  // Each write is {addr[31:0], data[31:0], we[3:0]}.
  logic [67:0] obs_q[$];
  logic [67:0] exp_q[$];
  logic [3:0]  pay_way[64];
  logic [31:0] pay_row[64];
  bit          exp_err;
  int          last_k;

  base_address_wr_if bus();

  base_address_wr #(
    .START_ADDR   (START),
    .DEPTH        (DEPTH),
    .C_DATA_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .bus           (bus),
    .busy          (busy),
    .range_err     (range_err),
    .Transfer_Done (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_en) obs_q.push_back({bus.ram_addr, bus.ram_wd_data, bus.ram_we});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_ram_en"}, {31'd0, bus.ram_en}, 32'd0);
    check({tag, "_ram_we"}, {28'd0, bus.ram_we}, 32'd0);
    check({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
    check({tag, "_ram_wd"}, bus.ram_wd_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_range_err"}, {31'd0, range_err}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic fill_rand(input bit big);
    logic [31:0] r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      pay_way[i] = r[3:0];
      r = $urandom;
      pay_row[i] = big ? r : {4'h0, r[27:0]};
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start        = 1'b1;
    bus.in_valid = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // Offer entries until the model says the table is closed, then check the
  // count word, the completion pulse and the full write list.
  task automatic run_table(input int n, input bit mark_last, input int pct,
                           input int restart_at, input bit offer_extra);
    int k;
    int cyc;
    bit prev_acc;
    bit ready_m;
    bit acc;
    k = 0; cyc = 0; prev_acc = 1'b0; ready_m = 1'b1;
    while (ready_m && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      check("wr_timing", {31'd0, bus.ram_en}, {31'd0, prev_acc});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, ready_m});
      check("busy", {31'd0, busy}, 32'd1);
      check("range_err_live", {31'd0, range_err}, {31'd0, exp_err});
      bus.in_valid = ($urandom_range(99) < pct);
      bus.in_way   = pay_way[k];
      bus.in_row   = pay_row[k];
      bus.in_last  = mark_last && (k == n - 1);
      if (restart_at >= 0 && k == restart_at) start = 1'b1;
      acc = bus.in_valid && ready_m;
      if (acc) begin
        exp_q.push_back({START + 32'(k * 4), pay_way[k], pay_row[k][27:0], 4'hF});
        if (pay_row[k][31:28] != 4'h0) exp_err = 1'b1;
        k++;
        if (bus.in_last || k == DEPTH) ready_m = 1'b0;
      end
      prev_acc = acc;
    end
    if (ready_m) check("accept_budget", 32'(k), 32'(n));
    last_k = k;

    @(negedge clk);
    start = 1'b0;
    check("last_wr_en", {31'd0, bus.ram_en}, {31'd0, prev_acc});
    check("ready_after_last", {31'd0, bus.in_ready}, 32'd0);
    check("done_early", {31'd0, done}, 32'd0);
    if (offer_extra) begin
      bus.in_valid = 1'b1;
      bus.in_way   = pay_way[k];
      bus.in_row   = pay_row[k];
      bus.in_last  = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
    exp_q.push_back({CADDR, 32'(k), 4'hF});

    @(negedge clk);
    check("count_en", {31'd0, bus.ram_en}, 32'd1);
    check("count_addr", bus.ram_addr, CADDR);
    check("count_data", bus.ram_wd_data, 32'(k));
    check("busy_count", {31'd0, busy}, 32'd1);
    check("done_at_count", {31'd0, done}, 32'd0);

    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("en_after_count", {31'd0, bus.ram_en}, 32'd0);
    check("range_err_end", {31'd0, range_err}, {31'd0, exp_err});

    @(negedge clk);
    check("done_width", {31'd0, done}, 32'd0);
    check("ready_idle", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;

    check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("wr_addr", obs_q[i][67:36], exp_q[i][67:36]);
      check("wr_data", obs_q[i][35:4], exp_q[i][35:4]);
      check("wr_we", {28'd0, obs_q[i][3:0]}, {28'd0, exp_q[i][3:0]});
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_way      = 4'h0;
    bus.in_row      = 32'h0;
    bus.in_last     = 1'b0;
    bus.ram_rd_data = 32'h0;
    exp_err         = 1'b0;
    last_k          = 0;

    #12;
    check_all_zero("reset");
    check("ram_rst_high", {31'd0, bus.ram_rst}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ram_rst_low", {31'd0, bus.ram_rst}, 32'd0);
    check("ram_clk", {31'd0, bus.ram_clk}, {31'd0, clk});

    // Three directed entries with in_last on the third.
    pay_way[0] = 4'd1; pay_row[0] = 32'h0000_0010;
    pay_way[1] = 4'd2; pay_row[1] = 32'h0000_0020;
    pay_way[2] = 4'd3; pay_row[2] = 32'h0000_0030;
    do_start();
    run_table(3, 1'b1, 100, -1, 1'b0);
    if (obs_q.size() == 4) begin
      check("tp_data0", obs_q[0][35:4], 32'h1000_0010);
      check("tp_addr2", obs_q[2][67:36], 32'h4580_0008);
      check("tp_data2", obs_q[2][35:4], 32'h3000_0030);
      check("tp_count_addr", obs_q[3][67:36], 32'h4580_0080);
      check("tp_count", obs_q[3][35:4], 32'd3);
    end else begin
      check("tp_writes", 32'(obs_q.size()), 32'd4);
    end

    // Full table without in_last; a 33rd entry is then offered.
    fill_rand(1'b0);
    do_start();
    run_table(DEPTH + 1, 1'b0, 100, -1, 1'b1);
    check("full_entries", 32'(last_k), 32'(DEPTH));

    // Out-of-range row: truncated pointer written, range_err sticky.
    pay_way[0] = 4'd5; pay_row[0] = 32'hF000_0001;
    do_start();
    run_table(1, 1'b1, 100, -1, 1'b0);
    if (obs_q.size() > 0) check("range_data", obs_q[0][35:4], 32'h5000_0001);
    repeat (3) @(negedge clk);
    check("range_err_hold", {31'd0, range_err}, 32'd1);

    // Randomized back-pressure with random high row nibbles.
    fill_rand(1'b1);
    do_start();
    run_table(20, 1'b1, 40, -1, 1'b0);

    // Reset after two of five entries.
    fill_rand(1'b0);
    do_start();
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_way = pay_way[0]; bus.in_row = pay_row[0]; bus.in_last = 1'b0;
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_way = pay_way[1]; bus.in_row = pay_row[1];
    check("rst_wr0_en", {31'd0, bus.ram_en}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_wr1_addr", bus.ram_addr, START + 32'd4);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_hold_en", {31'd0, bus.ram_en}, 32'd0);
      check("rst_hold_done", {31'd0, done}, 32'd0);
    end
    check("rst_writes", 32'(obs_q.size()), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand(1'b0);
    do_start();
    run_table(3, 1'b1, 70, -1, 1'b0);
    if (obs_q.size() > 0) check("rst_restart_addr", obs_q[0][67:36], START);

    // start pulsed while busy must be ignored.
    fill_rand(1'b1);
    do_start();
    run_table(6, 1'b1, 70, 3, 1'b0);
    check("restart_entries", 32'(last_k), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
